// File: rtl/hello_scroll_fsm.sv
// hello_scroll_fsm
//
// Scrolls the ring message "HELLO___" across a bank of active-low
// 7-segment digits. Each wrap of an upstream 16-bit counter, seen as a
// falling edge on q[15], is one scroll tick. A run input gates scrolling
// through a small IDLE / SCROLL / HOLD state machine.
//
// Optional build macro: HELLO_SCROLL_DIR_EN
//   When defined, adds input "dir". dir=0 scrolls left (ptr increments).
//   dir=1 scrolls right (ptr decrements, 0 -> 7). dir is sampled on the
//   cycle the step pulse is applied to ptr.
//
// Ports:
//   clock  in   system clock, all state changes on the rising edge
//   reset  in   synchronous, active-high; overrides every other input
//   q      in   [15:0] counter value from upstream
//   run    in   1 = scroll on ticks, 0 = idle (from IDLE) / freeze (from SCROLL)
//   dir    in   scroll direction (only with HELLO_SCROLL_DIR_EN)
//   hex    out  [7*NUM_DIGITS-1:0] segment codes, active-low gfedcba;
//               digit k is hex[7k+6:7k], k=0 is the rightmost digit
//   step   out  registered one-cycle pulse per detected counter wrap
//   state  out  [1:0] current FSM state for debug (IDLE=0, SCROLL=1, HOLD=2)
//
// Handshake note: there is no valid/ready traffic here. q is sampled every
// cycle unconditionally; step is a single-cycle strobe with no back-pressure.
module hello_scroll_fsm #(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [15:0]             q,
  input  logic                    run,
`ifdef HELLO_SCROLL_DIR_EN
  input  logic                    dir,
`endif
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    step,
  output logic [1:0]              state
);

  localparam int PTR_W = $clog2(MSG_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [PTR_W-1:0]        ptr_q;
  logic [PTR_W-1:0]        ptr_d;
  logic [PTR_W-1:0]        ptr_adv;
  logic                    prev_msb;
  logic                    wrap;
  logic [7*NUM_DIGITS-1:0] hex_d;

  // Only the MSB of the counter matters for tick detection.
  logic unused_q;
  assign unused_q = ^q[14:0];

  // Message ring H,E,L,L,O,blank,blank,blank in active-low gfedcba.
  function automatic logic [6:0] char_code(input logic [PTR_W-1:0] idx);
    logic [6:0] code;
    case (idx)
      3'd0:    code = 7'h09; // H
      3'd1:    code = 7'h06; // E
      3'd2:    code = 7'h47; // L
      3'd3:    code = 7'h47; // L
      3'd4:    code = 7'h40; // O
      default: code = 7'h7F; // blank
    endcase
    return code;
  endfunction

  // A wrap is q[15] going 1 -> 0; a rise never counts.
  assign wrap = prev_msb & ~q[15];

`ifdef HELLO_SCROLL_DIR_EN
  assign ptr_adv = dir ? (ptr_q - 1'b1) : (ptr_q + 1'b1);
`else
  assign ptr_adv = ptr_q + 1'b1;
`endif

  // Next-state, next-ptr and next-display logic.
  always_comb begin
    state_d = IDLE;
    ptr_d   = ptr_q;
    hex_d   = '1;

    case (state_q)
      IDLE: begin
        ptr_d = '0;
        if (run) state_d = SCROLL;
        else     state_d = IDLE;
      end
      SCROLL: begin
        // Dropping run wins over a simultaneous step: freeze, no advance.
        if (!run) begin
          state_d = HOLD;
        end else begin
          state_d = SCROLL;
          if (step) ptr_d = ptr_adv;
        end
      end
      HOLD: begin
        if (run) state_d = SCROLL;
        else     state_d = HOLD;
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase

    // Display window follows the current (registered) state and ptr.
    if (state_q == SCROLL || state_q == HOLD) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        hex_d[7*k +: 7] = char_code(ptr_q + PTR_W'(NUM_DIGITS - 1 - k));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      prev_msb <= 1'b0;
      step     <= 1'b0;
      hex      <= '1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      prev_msb <= q[15];
      step     <= wrap;
      hex      <= hex_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_hello_scroll_fsm.sv
module tb_hello_scroll_fsm;

  localparam int ND = 6;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   q     = '0;
  logic          run   = 1'b0;
  logic          dir   = 1'b0;
  logic [7*ND-1:0] hex;
  logic          step;
  logic [1:0]    state;

  always #5 clock = ~clock;

  hello_scroll_fsm #(.NUM_DIGITS(ND)) dut (
    .clock (clock),
    .reset (reset),
    .q     (q),
    .run   (run),
`ifdef HELLO_SCROLL_DIR_EN
    .dir   (dir),
`endif
    .hex   (hex),
    .step  (step),
    .state (state)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode: 0 idle, 1 scrolling, 2 held. Position in the 8-character ring.
  string msg_s = "HELLO   ";
  int    m_mode = 0;
  int    m_pos  = 0;
  bit    m_prev = 0;
  bit    m_step = 0;
  logic [7*ND-1:0] m_hex = '1;

  function automatic logic [6:0] seg_of(input byte c);
    case (c)
      "H":     return 7'h09;
      "E":     return 7'h06;
      "L":     return 7'h47;
      "O":     return 7'h40;
      default: return 7'h7F;
    endcase
  endfunction

  // Leftmost digit shows the character at pos, the next one pos+1, etc.
  function automatic logic [7*ND-1:0] window(input int mode, input int pos);
    logic [7*ND-1:0] w;
    w = '1;
    if (mode != 0) begin
      for (int col = 0; col < ND; col++) begin
        int k;
        k = ND - 1 - col;
        w[7*k +: 7] = seg_of(msg_s[(pos + col) % 8]);
      end
    end
    return w;
  endfunction

  task automatic model_edge();
    bit new_step;
    if (reset) begin
      m_mode = 0; m_pos = 0; m_prev = 0; m_step = 0; m_hex = '1;
    end else begin
      new_step = m_prev && !q[15];
      m_hex    = window(m_mode, m_pos);
      case (m_mode)
        0: if (run) begin m_mode = 1; m_pos = 0; end
        1: begin
          if (!run) m_mode = 2;
          else if (m_step) begin
`ifdef HELLO_SCROLL_DIR_EN
            m_pos = dir ? (m_pos + 7) % 8 : (m_pos + 1) % 8;
`else
            m_pos = (m_pos + 1) % 8;
`endif
          end
        end
        default: if (run) m_mode = 1;
      endcase
      m_prev = q[15];
      m_step = new_step;
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle(input logic r, input logic rn, input logic [15:0] qv);
    reset = r;
    run   = rn;
    q     = qv;
    @(posedge clock);
    model_edge();
    #1;
    check("step",  {63'd0, step}, {63'd0, m_step});
    check("state", {62'd0, state}, 64'(m_mode));
    check("hex",   64'(hex), 64'(m_hex));
  endtask

  task automatic do_wrap(input logic rn);
    do_cycle(1'b0, rn, 16'hFFFF);
    do_cycle(1'b0, rn, 16'h0000);
  endtask

  logic [7*ND-1:0] win0;
  logic [7*ND-1:0] win1;
  logic [7*ND-1:0] blank_all;
  logic [15:0]     cnt;

  initial begin
    win0      = {7'h09, 7'h06, 7'h47, 7'h47, 7'h40, 7'h7F};
    win1      = {7'h06, 7'h47, 7'h47, 7'h40, 7'h7F, 7'h7F};
    blank_all = 42'h3FFFFFFFFFF;

    // Reset held with q toggling.
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 1'b0, 16'($urandom));
      check("rst_hex", 64'(hex), 64'(blank_all));
      check("rst_state", {62'd0, state}, 64'd0);
      check("rst_step", {63'd0, step}, 64'd0);
    end

    // Start scrolling from IDLE.
    do_cycle(1'b0, 1'b1, 16'h0000);
    check("start_state", {62'd0, state}, 64'd1);
    do_cycle(1'b0, 1'b1, 16'h0000);
    check("start_hex", 64'(hex), 64'(win0));

    // One wrap: step pulse, then window advances two cycles later.
    do_wrap(1'b1);
    check("wrap_step", {63'd0, step}, 64'd1);
    do_cycle(1'b0, 1'b1, 16'h0000);
    check("wrap_step_gone", {63'd0, step}, 64'd0);
    do_cycle(1'b0, 1'b1, 16'h0000);
    check("wrap_hex", 64'(hex), 64'(win1));

    // Seven more wraps return to the original window.
    for (int i = 0; i < 7; i++) do_wrap(1'b1);
    do_cycle(1'b0, 1'b1, 16'h0000);
    do_cycle(1'b0, 1'b1, 16'h0000);
    check("ring_hex", 64'(hex), 64'(win0));

    // MSB rise is not a wrap.
    do_cycle(1'b0, 1'b1, 16'h7FFF);
    do_cycle(1'b0, 1'b1, 16'h8000);
    do_cycle(1'b0, 1'b1, 16'h8000);
    check("rise_step", {63'd0, step}, 64'd0);

    // Drop run on the step cycle: HOLD, no advance, frozen display.
    do_cycle(1'b0, 1'b1, 16'h0000); // 8000 -> 0000 counts as a wrap
    check("clr_step", {63'd0, step}, 64'd1);
    do_cycle(1'b0, 1'b0, 16'h0000);
    check("hold_state", {62'd0, state}, 64'd2);
    for (int i = 0; i < 3; i++) do_wrap(1'b0);
    do_cycle(1'b0, 1'b0, 16'h0000);
    check("hold_hex", 64'(hex), 64'(win0));
    do_cycle(1'b0, 1'b1, 16'h0000);
    do_wrap(1'b1);
    do_cycle(1'b0, 1'b1, 16'h0000);
    do_cycle(1'b0, 1'b1, 16'h0000);
    check("resume_hex", 64'(hex), 64'(win1));

    // Advance to ptr 5, then reset mid-scroll.
    for (int i = 0; i < 4; i++) do_wrap(1'b1);
    do_cycle(1'b0, 1'b1, 16'h0000);
    do_cycle(1'b1, 1'b1, 16'h0000);
    check("midrst_hex", 64'(hex), 64'(blank_all));
    check("midrst_state", {62'd0, state}, 64'd0);

`ifdef HELLO_SCROLL_DIR_EN
    dir = 1'b1;
    do_cycle(1'b0, 1'b1, 16'h0000);
    do_wrap(1'b1);
    do_cycle(1'b0, 1'b1, 16'h0000);
    do_cycle(1'b0, 1'b1, 16'h0000);
    check("dir_digit5", 64'(hex[7*ND-1 -: 7]), 64'h7F);
`endif

    // Randomised phase against the model.
    cnt = 16'($urandom);
    for (int i = 0; i < 1500; i++) begin
      dir = 1'($urandom);
      cnt = cnt + 16'($urandom_range(0, 16384));
      do_cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hello_scroll_fsm.md
Name: hello_scroll_fsm

Overview:
- Downstream consumer of the 16-bit free-running counter value (q[15:0]).
- Detects each counter wrap (MSB falling edge) and uses it as a slow scroll tick.
- Drives an NUM_DIGITS-wide bank of active-low 7-segment displays with the ring message "HELLO___", scrolling one position per tick.
- A small FSM gates scrolling with a run control.

Parameters:
- NUM_DIGITS, 6, number of 7-segment digits driven; legal 1..8.
- MSG_LEN, 8, message ring length; fixed at 8 (H,E,L,L,O,blank,blank,blank); not to be overridden.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- q  input  16  counter value from the upstream 16-bit counter.
- run  input  1  1 = scroll on ticks; 0 = idle (from IDLE) or freeze (from SCROLL).
- hex  output  7*NUM_DIGITS  segment codes, active-low, gfedcba per digit; digit k occupies hex[7k+6:7k]; k=0 is the rightmost digit.
- step  output  1  one-cycle pulse, registered, on each detected counter wrap.
- state  output  2  current FSM state, for debug (IDLE=0, SCROLL=1, HOLD=2).

Behaviour:
- Interface: one clock "clock"; "reset" is synchronous and active-high; reset has priority over every other input.
- Reset values:
  - hex = all 7'h7F (blank).
  - step = 0.
  - state = IDLE.
  - ptr (3-bit message index) = 0.
  - prev_msb = 0.
- Tick detection:
  - prev_msb <= q[15] every cycle.
  - wrap = prev_msb & ~q[15].
  - step <= wrap, so step is high exactly one cycle, one cycle after q[15] falls.
  - A q[15] rise never produces step.
  - If q goes 16'h8000 directly to 16'h0000 (upstream cleared), that counts as a wrap.
- Character encodings (active-low):
  - H = 7'h09, E = 7'h06, L = 7'h47, O = 7'h40, blank = 7'h7F.
  - msg[0..7] = H,E,L,L,O,blank,blank,blank.
- Display mapping:
  - In SCROLL and HOLD, digit k shows msg[(ptr + NUM_DIGITS-1-k) mod 8].
  - At ptr=0 with NUM_DIGITS=6, display left to right reads H E L L O blank.
  - In IDLE, all digits are blank.
  - hex is registered and reflects state/ptr one cycle after they change.
- FSM (all transitions evaluated on a cycle where reset=0):
  - IDLE: run=1 -> SCROLL with ptr=0; display shows the ptr=0 window on the next cycle. Otherwise stay in IDLE.
  - SCROLL:
    - run=0 -> HOLD.
    - run=1 and step=1 -> ptr <= ptr+1 mod 8, stay in SCROLL.
    - Otherwise hold ptr.
  - HOLD: ptr is frozen and the display is frozen. run=1 -> SCROLL, ptr kept (no restart).
  - Encodings 3 and any other illegal state -> IDLE next cycle.
- ptr arithmetic: 3-bit, wraps 7 -> 0 naturally; 8 steps return the display to its original window.
- Simultaneous events:
  - run falling on the same cycle as step=1: HOLD is taken and ptr is not advanced.
  - reset together with step: reset wins.
  - The step pulse itself still follows wrap in all states (it is not gated by run).
- Reset mid-scroll: the next cycle shows all blank, state IDLE, ptr 0; scrolling resumes from ptr 0 only after run=1.
- Latency, q[15] falling edge -> hex change: 3 cycles.
  - Cycle 1: step register.
  - Cycle 2: ptr update.
  - Cycle 3: hex register.

Optional Feature:
- Macro: HELLO_SCROLL_DIR_EN.
- When defined:
  - Adds input port dir (1 bit).
  - dir=0: ptr increments per step (scroll left).
  - dir=1: ptr decrements mod 8 (scroll right; 0 -> 7).
  - dir is sampled on the step cycle.
- When undefined: no dir port; ptr only increments.
- All other behaviour is identical in both builds.

Test Plan:
- Reset held 3 cycles with q toggling -> hex = all 7'h7F, step=0, state=0 throughout; hex = 42'h3FFFFFFFFFF for NUM_DIGITS=6.
- run=1, q held 16'h0000 -> state=1 next cycle; one cycle later hex digits 5..0 = 09,06,47,47,40,7F; no step pulses.
- run=1; drive q 16'hFFFF then 16'h0000 -> step=1 for exactly one cycle (cycle after 16'h0000); ptr=1; hex digits 5..0 = 06,47,47,40,7F,7F two cycles after step.
- 8 wrap events in SCROLL -> ptr returns to 0, display equals the initial window; drive q 16'h7FFF -> 16'h8000 -> step stays 0.
- Drop run on the same cycle as step=1 -> state=2, ptr unchanged; further wraps leave hex frozen; raise run -> scrolling continues from the held ptr.
- Assert reset during SCROLL at ptr=5 -> next cycle all blank, state=0, ptr=0; with HELLO_SCROLL_DIR_EN defined, dir=1 and one wrap from ptr=0 -> ptr=7, digit 5 = 7'h7F.
